mc_controller: RTL and testbench
================================

Name: mc_controller

Overview:
Multicycle control FSM that sequences the 16-bit datapath over several clocks per instruction. It drives all datapath control strobes (memtoreg, pcsrc, alusrc, regdst, regwrite, jump, alucontrol) plus the multicycle enables (pcwrite, irwrite, iord, memread, memwrite). It handshakes with a shared single-port instruction/data memory through mem_ready, and a watchdog guards every memory wait. It sits between the instruction register fields and the datapath inside the cpu top.

Parameters:
MAX_WAIT, 8, maximum cycles spent waiting for mem_ready in one memory state before a fault.
CW, 4, width of the wait counter; must satisfy 2^CW > MAX_WAIT.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-low reset; sampled on rising clk
opcode  input  4  instr[15:12] from the instruction register
funct  input  3  instr[2:0], R-type function
zero  input  1  ALU zero flag
mem_ready  input  1  memory completes the current access this cycle
pcwrite  output  1  PC register load enable
pcsrc  output  1  selects branch target
jump  output  1  selects jump target
irwrite  output  1  instruction register load enable
iord  output  1  0 = memory address from PC, 1 = from ALU out
memread  output  1  memory read request
memwrite  output  1  memory write request
memtoreg  output  1  write-back selects memory data
regdst  output  1  1 = rd field, 0 = rt field
alusrc  output  1  1 = sign-extended immediate
regwrite  output  1  register file write enable
alucontrol  output  4  ALU operation
halted  output  1  sticky; CPU stopped by a HALT instruction
fault  output  1  sticky; illegal opcode/funct or memory timeout

Behaviour:
- Reset: while reset==0 at a rising edge, state goes to FETCH, the wait counter clears, and halted/fault clear. While reset is low, every output is forced to 0; alucontrol is forced to 4'b0010.
- Reset asserted mid-instruction aborts the instruction with no partial write. This holds in every state.
- Opcodes:
  - 0000 R-type
  - 0001 LW
  - 0010 SW
  - 0011 BEQ
  - 0100 ADDI
  - 0101 J
  - 1111 HALT
  - any other opcode is illegal
- funct to alucontrol:
  - 000 ADD = 0010
  - 001 SUB = 0110
  - 010 AND = 0000
  - 011 OR = 0001
  - 100 SLT = 0111
  - 101-111 are illegal
- alucontrol is 0010 in every state except RTYPE_EX and BRANCH.
- FETCH: iord=0, memread=1.
  - mem_ready=1: irwrite=1, pcwrite=1 (PC+2), go to DECODE.
  - Otherwise the counter increments.
- DECODE: all strobes 0. Transition by opcode:
  - LW/SW to MEMADR
  - R-type to RTYPE_EX
  - BEQ to BRANCH
  - ADDI to ADDI_EX
  - J to JUMP
  - HALT to HALT (halted=1)
  - illegal to FAULT
- MEMADR: alusrc=1. Go to MEMRD for LW, MEMWR for SW.
- MEMRD: iord=1, memread=1; on mem_ready go to MEMWB.
- MEMWB: regwrite=1, memtoreg=1, regdst=0, then FETCH.
- MEMWR: iord=1, memwrite=1; on mem_ready go to FETCH.
- RTYPE_EX: alucontrol from funct. An illegal funct goes to FAULT with no writeback; otherwise go to ALUWB.
- ALUWB: regwrite=1, regdst=1, memtoreg=0, then FETCH.
- BRANCH: alucontrol=0110, pcsrc=1, pcwrite=zero (same-cycle Mealy term), then FETCH.
- ADDI_EX: alusrc=1, then ADDI_WB.
- ADDI_WB: regwrite=1, regdst=0, then FETCH.
- JUMP: jump=1, pcwrite=1, then FETCH.
- Wait counter:
  - Clears on every state change.
  - Increments each cycle in FETCH, MEMRD or MEMWR while mem_ready=0.
  - When it reaches MAX_WAIT with mem_ready still 0, go to FAULT. mem_ready arriving on the same cycle wins; no fault.
- HALT and FAULT are absorbing (only reset exits). All strobes are 0. halted or fault is held at 1.
- memread and memwrite are never both 1. regwrite and pcwrite are never 1 in the same cycle.
- CPI: R/ADDI 4, LW 5, SW 4, BEQ 3, J 3 (zero-wait memory).

Decomposition:
- Package ctrl_pkg holds:
  - state_t enum: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPE_EX, ALUWB, BRANCH, ADDI_EX, ADDI_WB, JUMP, HALT, FAULT
  - opcode localparams
  - funct localparams
  - ALUCTL_* codes
- Sub-module aludec is purely combinational: funct[2:0] in, alucontrol[3:0] and illegal out. It is shared with any future single-cycle controller.
- The FSM, the wait counter and output decode live in mc_controller.

Test Plan:
- Reset held low 3 cycles, then released, mem_ready=1 -> during reset all outputs 0 and alucontrol=0010. First post-reset cycle: memread=1, iord=0, irwrite=1, pcwrite=1.
- R-type opcode=0000, funct=001, mem_ready=1 -> states FETCH, DECODE, RTYPE_EX (alucontrol=0110), ALUWB (regwrite=1, regdst=1), then FETCH. 4 cycles.
- LW with mem_ready delayed 3 cycles in MEMRD -> MEMRD holds memread=1, iord=1 for 4 cycles. MEMWB asserts regwrite=1, memtoreg=1. No fault.
- BEQ twice, zero=1 then zero=0 -> BRANCH cycle gives pcwrite=1, pcsrc=1 the first time; pcwrite=0 the second time. alucontrol=0110 both times.
- mem_ready stuck 0 in MEMWR with MAX_WAIT=8 -> fault=1 after 8 wait cycles. memwrite drops to 0 and stays 0. Reset low clears fault.
- opcode=1111, then opcode=0111, each after a reset -> the first gives halted=1 after DECODE; the second gives fault=1. Both hold all strobes 0 until reset.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle controller: FSM states, opcodes, funct codes and ALU controls.
package ctrl_pkg;

    localparam int unsigned OPW = 4;
    localparam int unsigned FNW = 3;
    localparam int unsigned ACW = 4;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        MEMADR,
        MEMRD,
        MEMWB,
        MEMWR,
        RTYPE_EX,
        ALUWB,
        BRANCH,
        ADDI_EX,
        ADDI_WB,
        JUMP,
        HALT,
        FAULT
    } state_t;

    localparam logic [OPW-1:0] OP_RTYPE = 4'b0000;
    localparam logic [OPW-1:0] OP_LW    = 4'b0001;
    localparam logic [OPW-1:0] OP_SW    = 4'b0010;
    localparam logic [OPW-1:0] OP_BEQ   = 4'b0011;
    localparam logic [OPW-1:0] OP_ADDI  = 4'b0100;
    localparam logic [OPW-1:0] OP_J     = 4'b0101;
    localparam logic [OPW-1:0] OP_HALT  = 4'b1111;

    localparam logic [FNW-1:0] FN_ADD = 3'b000;
    localparam logic [FNW-1:0] FN_SUB = 3'b001;
    localparam logic [FNW-1:0] FN_AND = 3'b010;
    localparam logic [FNW-1:0] FN_OR  = 3'b011;
    localparam logic [FNW-1:0] FN_SLT = 3'b100;

    localparam logic [ACW-1:0] ALUCTL_AND = 4'b0000;
    localparam logic [ACW-1:0] ALUCTL_OR  = 4'b0001;
    localparam logic [ACW-1:0] ALUCTL_ADD = 4'b0010;
    localparam logic [ACW-1:0] ALUCTL_SUB = 4'b0110;
    localparam logic [ACW-1:0] ALUCTL_SLT = 4'b0111;

endpackage

// File: rtl/aludec.sv
// R-type funct to ALU control decoder; purely combinational so it can be reused by other controllers.
module aludec
    import ctrl_pkg::*;
(
    input  logic [FNW-1:0] funct,
    output logic [ACW-1:0] alucontrol,
    output logic           illegal
);

    always_comb begin
        alucontrol = ALUCTL_ADD;
        illegal    = 1'b0;
        case (funct)
            FN_ADD:  alucontrol = ALUCTL_ADD;
            FN_SUB:  alucontrol = ALUCTL_SUB;
            FN_AND:  alucontrol = ALUCTL_AND;
            FN_OR:   alucontrol = ALUCTL_OR;
            FN_SLT:  alucontrol = ALUCTL_SLT;
            default: illegal    = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle control FSM for the 16-bit datapath, with a watchdog on every memory wait.
module mc_controller
    import ctrl_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 8,
    parameter int unsigned CW       = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [OPW-1:0] opcode,
    input  logic [FNW-1:0] funct,
    input  logic           zero,
    input  logic           mem_ready,
    output logic           pcwrite,
    output logic           pcsrc,
    output logic           jump,
    output logic           irwrite,
    output logic           iord,
    output logic           memread,
    output logic           memwrite,
    output logic           memtoreg,
    output logic           regdst,
    output logic           alusrc,
    output logic           regwrite,
    output logic [ACW-1:0] alucontrol,
    output logic           halted,
    output logic           fault
);

    state_t          state;
    state_t          state_next;
    logic [CW-1:0]   wait_cnt;
    logic [CW-1:0]   wait_next;
    logic            mem_wait;
    logic [ACW-1:0]  alu_fn;
    logic            fn_illegal;

    aludec u_aludec (
        .funct      (funct),
        .alucontrol (alu_fn),
        .illegal    (fn_illegal)
    );

    // State and watchdog registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= FETCH;
            wait_cnt <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_next;
        end
    end

    // Next state and strobe decode; everything stays idle while reset is low.
    always_comb begin
        state_next = state;
        wait_next  = wait_cnt;
        mem_wait   = 1'b0;
        pcwrite    = 1'b0;
        pcsrc      = 1'b0;
        jump       = 1'b0;
        irwrite    = 1'b0;
        iord       = 1'b0;
        memread    = 1'b0;
        memwrite   = 1'b0;
        memtoreg   = 1'b0;
        regdst     = 1'b0;
        alusrc     = 1'b0;
        regwrite   = 1'b0;
        alucontrol = ALUCTL_ADD;
        halted     = 1'b0;
        fault      = 1'b0;

        if (reset) begin
            case (state)
                FETCH: begin
                    memread = 1'b1;
                    if (mem_ready) begin
                        irwrite    = 1'b1;
                        pcwrite    = 1'b1;
                        state_next = DECODE;
                    end else begin
                        mem_wait = 1'b1;
                    end
                end
                DECODE: begin
                    case (opcode)
                        OP_LW, OP_SW: state_next = MEMADR;
                        OP_RTYPE:     state_next = RTYPE_EX;
                        OP_BEQ:       state_next = BRANCH;
                        OP_ADDI:      state_next = ADDI_EX;
                        OP_J:         state_next = JUMP;
                        OP_HALT:      state_next = HALT;
                        default:      state_next = FAULT;
                    endcase
                end
                MEMADR: begin
                    alusrc     = 1'b1;
                    state_next = (opcode == OP_SW) ? MEMWR : MEMRD;
                end
                MEMRD: begin
                    iord    = 1'b1;
                    memread = 1'b1;
                    if (mem_ready) state_next = MEMWB;
                    else           mem_wait   = 1'b1;
                end
                MEMWB: begin
                    regwrite   = 1'b1;
                    memtoreg   = 1'b1;
                    state_next = FETCH;
                end
                MEMWR: begin
                    iord     = 1'b1;
                    memwrite = 1'b1;
                    if (mem_ready) state_next = FETCH;
                    else           mem_wait   = 1'b1;
                end
                RTYPE_EX: begin
                    alucontrol = alu_fn;
                    state_next = fn_illegal ? FAULT : ALUWB;
                end
                ALUWB: begin
                    regwrite   = 1'b1;
                    regdst     = 1'b1;
                    state_next = FETCH;
                end
                BRANCH: begin
                    alucontrol = ALUCTL_SUB;
                    pcsrc      = 1'b1;
                    pcwrite    = zero;
                    state_next = FETCH;
                end
                ADDI_EX: begin
                    alusrc     = 1'b1;
                    state_next = ADDI_WB;
                end
                ADDI_WB: begin
                    regwrite   = 1'b1;
                    state_next = FETCH;
                end
                JUMP: begin
                    jump       = 1'b1;
                    pcwrite    = 1'b1;
                    state_next = FETCH;
                end
                HALT:    halted     = 1'b1;
                FAULT:   fault      = 1'b1;
                default: state_next = FAULT;
            endcase

            // Counter is allowed to reach MAX_WAIT; a ready on that same cycle still completes.
            if (mem_wait) begin
                if (wait_cnt == CW'(MAX_WAIT)) state_next = FAULT;
                else                           wait_next  = wait_cnt + CW'(1);
            end
            if (state_next != state) wait_next = '0;
        end
    end

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: per-cycle expected strobe vectors through a scoreboard queue.
module tb_mc_controller;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] opcode = 4'h0;
    logic [2:0] funct = 3'h0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b1;
    logic       pcwrite, pcsrc, jump, irwrite, iord, memread, memwrite;
    logic       memtoreg, regdst, alusrc, regwrite, halted, fault;
    logic [3:0] alucontrol;

    mc_controller #(.MAX_WAIT(8), .CW(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .funct      (funct),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .pcwrite    (pcwrite),
        .pcsrc      (pcsrc),
        .jump       (jump),
        .irwrite    (irwrite),
        .iord       (iord),
        .memread    (memread),
        .memwrite   (memwrite),
        .memtoreg   (memtoreg),
        .regdst     (regdst),
        .alusrc     (alusrc),
        .regwrite   (regwrite),
        .alucontrol (alucontrol),
        .halted     (halted),
        .fault      (fault)
    );

    always #5 clk = ~clk;

    // {pcwrite,pcsrc,jump,irwrite,iord,memread,memwrite,memtoreg,regdst,alusrc,regwrite,alucontrol,halted,fault}
    logic [16:0] obs;
    assign obs = {pcwrite, pcsrc, jump, irwrite, iord, memread, memwrite, memtoreg,
                  regdst, alusrc, regwrite, alucontrol, halted, fault};

    localparam logic [16:0] M_PCW  = 17'h10000;
    localparam logic [16:0] M_PCS  = 17'h08000;
    localparam logic [16:0] M_JMP  = 17'h04000;
    localparam logic [16:0] M_IRW  = 17'h02000;
    localparam logic [16:0] M_IORD = 17'h01000;
    localparam logic [16:0] M_MRD  = 17'h00800;
    localparam logic [16:0] M_MWR  = 17'h00400;
    localparam logic [16:0] M_M2R  = 17'h00200;
    localparam logic [16:0] M_RDST = 17'h00100;
    localparam logic [16:0] M_ASRC = 17'h00080;
    localparam logic [16:0] M_RWR  = 17'h00040;
    localparam logic [16:0] A_ADD  = 17'h00008;
    localparam logic [16:0] A_SUB  = 17'h00018;
    localparam logic [16:0] A_MASK = 17'h0003C;
    localparam logic [16:0] M_HLT  = 17'h00002;
    localparam logic [16:0] M_FLT  = 17'h00001;
    localparam logic [16:0] FV     = M_PCW | M_IRW | M_MRD | A_ADD;

    localparam logic [3:0] OPR  = 4'h0;
    localparam logic [3:0] OLW  = 4'h1;
    localparam logic [3:0] OSW  = 4'h2;
    localparam logic [3:0] OBEQ = 4'h3;
    localparam logic [3:0] OADI = 4'h4;
    localparam logic [3:0] OJ   = 4'h5;
    localparam logic [3:0] OHLT = 4'hF;
    localparam logic [3:0] OBAD = 4'h7;

    typedef struct {
        string       tag;
        logic [16:0] v;
        logic [16:0] dc;
    } exp_t;

    exp_t        sb[$];
    logic [16:0] dc = '0;
    int          tests = 0;
    int          fails = 0;

    // Drive one cycle of inputs, queue what the outputs must be, then check them mid-cycle.
    task automatic cyc(input string tag, input logic r, input logic [3:0] op, input logic [2:0] fn,
                       input logic z, input logic mr, input logic [16:0] e);
        exp_t x;
        @(negedge clk);
        reset     = r;
        opcode    = op;
        funct     = fn;
        zero      = z;
        mem_ready = mr;
        x.tag = tag;
        x.v   = e;
        x.dc  = dc;
        sb.push_back(x);
        #2;
        x = sb.pop_front();
        tests++;
        assert ((obs & ~x.dc) === (x.v & ~x.dc))
        else begin
            fails++;
            $error("FAIL %s: observed %05h expected %05h", x.tag, obs, x.v);
        end
        tests++;
        assert (((memread & memwrite) === 1'b0) && ((regwrite & pcwrite) === 1'b0))
        else begin
            fails++;
            $error("FAIL %s_excl: observed rd/wr/rw/pw %b%b%b%b expected no pair high",
                   x.tag, memread, memwrite, regwrite, pcwrite);
        end
    endtask

    initial begin
        repeat (3) cyc("rst", 1'b0, OPR, 3'd1, 1'b0, 1'b1, A_ADD);

        // R-type SUB
        cyc("r_fetch", 1'b1, OPR, 3'd1, 1'b0, 1'b1, FV);
        cyc("r_dec",   1'b1, OPR, 3'd1, 1'b0, 1'b1, A_ADD);
        cyc("r_ex",    1'b1, OPR, 3'd1, 1'b0, 1'b1, A_SUB);
        cyc("r_wb",    1'b1, OPR, 3'd1, 1'b0, 1'b1, M_RWR | M_RDST | A_ADD);

        // LW with three wait cycles in MEMRD
        cyc("lw_fetch", 1'b1, OLW, 3'd0, 1'b0, 1'b1, FV);
        cyc("lw_dec",   1'b1, OLW, 3'd0, 1'b0, 1'b1, A_ADD);
        cyc("lw_adr",   1'b1, OLW, 3'd0, 1'b0, 1'b1, M_ASRC | A_ADD);
        repeat (3) cyc("lw_wait", 1'b1, OLW, 3'd0, 1'b0, 1'b0, M_IORD | M_MRD | A_ADD);
        cyc("lw_rd",    1'b1, OLW, 3'd0, 1'b0, 1'b1, M_IORD | M_MRD | A_ADD);
        cyc("lw_wb",    1'b1, OLW, 3'd0, 1'b0, 1'b1, M_RWR | M_M2R | A_ADD);

        // BEQ taken then not taken
        cyc("beq1_fetch", 1'b1, OBEQ, 3'd0, 1'b1, 1'b1, FV);
        cyc("beq1_dec",   1'b1, OBEQ, 3'd0, 1'b1, 1'b1, A_ADD);
        cyc("beq_taken",  1'b1, OBEQ, 3'd0, 1'b1, 1'b1, M_PCW | M_PCS | A_SUB);
        cyc("beq2_fetch", 1'b1, OBEQ, 3'd0, 1'b0, 1'b1, FV);
        cyc("beq2_dec",   1'b1, OBEQ, 3'd0, 1'b0, 1'b1, A_ADD);
        cyc("beq_not",    1'b1, OBEQ, 3'd0, 1'b0, 1'b1, M_PCS | A_SUB);

        // J and ADDI
        cyc("j_fetch",   1'b1, OJ, 3'd0, 1'b0, 1'b1, FV);
        cyc("j_dec",     1'b1, OJ, 3'd0, 1'b0, 1'b1, A_ADD);
        cyc("j_jump",    1'b1, OJ, 3'd0, 1'b0, 1'b1, M_JMP | M_PCW | A_ADD);
        cyc("ad_fetch",  1'b1, OADI, 3'd0, 1'b0, 1'b1, FV);
        cyc("ad_dec",    1'b1, OADI, 3'd0, 1'b0, 1'b1, A_ADD);
        cyc("ad_ex",     1'b1, OADI, 3'd0, 1'b0, 1'b1, M_ASRC | A_ADD);
        cyc("ad_wb",     1'b1, OADI, 3'd0, 1'b0, 1'b1, M_RWR | A_ADD);

        // Fetch stall, then SW whose ready lands exactly when the counter hits MAX_WAIT
        repeat (2) cyc("fetch_wait", 1'b1, OSW, 3'd0, 1'b0, 1'b0, M_MRD | A_ADD);
        cyc("sw_fetch", 1'b1, OSW, 3'd0, 1'b0, 1'b1, FV);
        cyc("sw_dec",   1'b1, OSW, 3'd0, 1'b0, 1'b1, A_ADD);
        cyc("sw_adr",   1'b1, OSW, 3'd0, 1'b0, 1'b1, M_ASRC | A_ADD);
        repeat (8) cyc("sw_wait", 1'b1, OSW, 3'd0, 1'b0, 1'b0, M_IORD | M_MWR | A_ADD);
        cyc("sw_late",  1'b1, OSW, 3'd0, 1'b0, 1'b1, M_IORD | M_MWR | A_ADD);
        cyc("sw_nofault_fetch", 1'b1, OSW, 3'd0, 1'b0, 1'b1, FV);

        // SW with memory stuck: watchdog fault, then reset clears it
        cyc("to_dec", 1'b1, OSW, 3'd0, 1'b0, 1'b1, A_ADD);
        cyc("to_adr", 1'b1, OSW, 3'd0, 1'b0, 1'b1, M_ASRC | A_ADD);
        repeat (9) cyc("to_wait", 1'b1, OSW, 3'd0, 1'b0, 1'b0, M_IORD | M_MWR | A_ADD);
        repeat (3) cyc("to_fault", 1'b1, OSW, 3'd0, 1'b0, 1'b1, M_FLT | A_ADD);
        cyc("to_rst", 1'b0, OSW, 3'd0, 1'b0, 1'b1, A_ADD);

        // Reset landing in ALUWB suppresses the writeback
        cyc("ab_fetch", 1'b1, OPR, 3'd0, 1'b0, 1'b1, FV);
        cyc("ab_dec",   1'b1, OPR, 3'd0, 1'b0, 1'b1, A_ADD);
        cyc("ab_ex",    1'b1, OPR, 3'd0, 1'b0, 1'b1, A_ADD);
        cyc("ab_rst",   1'b0, OPR, 3'd0, 1'b0, 1'b1, A_ADD);

        // HALT is absorbing until reset
        cyc("h_fetch", 1'b1, OHLT, 3'd0, 1'b0, 1'b1, FV);
        cyc("h_dec",   1'b1, OHLT, 3'd0, 1'b0, 1'b1, A_ADD);
        repeat (3) cyc("h_hold", 1'b1, OHLT, 3'd0, 1'b1, 1'b1, M_HLT | A_ADD);
        cyc("h_rst",   1'b0, OHLT, 3'd0, 1'b0, 1'b1, A_ADD);

        // Illegal opcode
        cyc("ill_fetch", 1'b1, OBAD, 3'd0, 1'b0, 1'b1, FV);
        cyc("ill_dec",   1'b1, OBAD, 3'd0, 1'b0, 1'b1, A_ADD);
        repeat (3) cyc("ill_hold", 1'b1, OBAD, 3'd0, 1'b1, 1'b1, M_FLT | A_ADD);
        cyc("ill_rst",   1'b0, OBAD, 3'd0, 1'b0, 1'b1, A_ADD);

        // Illegal funct: no writeback, straight to fault (ALU code that cycle is unconstrained)
        cyc("bf_fetch", 1'b1, OPR, 3'd5, 1'b0, 1'b1, FV);
        cyc("bf_dec",   1'b1, OPR, 3'd5, 1'b0, 1'b1, A_ADD);
        dc = A_MASK;
        cyc("bf_ex",    1'b1, OPR, 3'd5, 1'b0, 1'b1, A_ADD);
        dc = '0;
        repeat (2) cyc("bf_fault", 1'b1, OPR, 3'd5, 1'b0, 1'b1, M_FLT | A_ADD);
        cyc("bf_rst",   1'b0, OPR, 3'd5, 1'b0, 1'b1, A_ADD);
        cyc("bf_refetch", 1'b1, OPR, 3'd0, 1'b0, 1'b1, FV);

        tests++;
        assert (sb.size() === 0)
        else begin
            fails++;
            $error("FAIL sb_drain: observed %0d entries expected 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
